// File: rtl/alu_pkg.sv
// Shared constants for the mini-CPU ALU path: widths, opcodes, flag bit
// positions and the issue-stage state encoding.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int NREGS  = 8;
    localparam int REG_AW = 3;

    localparam logic [2:0] OP_ADDU = 3'd0;
    localparam logic [2:0] OP_SUBU = 3'd1;
    localparam logic [2:0] OP_ADDS = 3'd2;
    localparam logic [2:0] OP_SUBS = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_SLL  = 3'd7;

    localparam int FLAG_CF  = 3;
    localparam int FLAG_OVF = 2;
    localparam int FLAG_Z   = 1;
    localparam int FLAG_NEG = 0;

    typedef enum logic {IDLE, EXEC} state_t;

endpackage

// File: rtl/alu_regfile.sv
// NREGS x DATA_W register file: two operand read ports, one debug read port,
// writeback and host write ports with writeback priority; R0 reads as zero.
module alu_regfile #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              areset,
    input  logic [REG_AW-1:0] i_rs1_addr,
    input  logic [REG_AW-1:0] i_rs2_addr,
    input  logic [REG_AW-1:0] i_dbg_addr,
    output logic [DATA_W-1:0] o_rs1_data,
    output logic [DATA_W-1:0] o_rs2_data,
    output logic [DATA_W-1:0] o_dbg_data,
    input  logic              i_wb_we,
    input  logic [REG_AW-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_host_we,
    input  logic [REG_AW-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_data
);

    logic [DATA_W-1:0] r_mem [NREGS];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (!areset) begin
            for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (i_wb_we && i_wb_addr == REG_AW'(i))
                    r_mem[i] <= i_wb_data;
                else if (i_host_we && i_host_addr == REG_AW'(i))
                    r_mem[i] <= i_host_data;
            end
        end
    end

    assign o_rs1_data = (i_rs1_addr == '0) ? '0 : r_mem[i_rs1_addr];
    assign o_rs2_data = (i_rs2_addr == '0) ? '0 : r_mem[i_rs2_addr];
    assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Operand-issue / writeback stage in front of the 8-bit ALU.
// Optional immediate operand b is enabled with ALU_ISSUE_IMM_EN.
module alu_issue #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int NREGS  = alu_pkg::NREGS,
    parameter int REG_AW = alu_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
`ifdef ALU_ISSUE_IMM_EN
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_imm,
`endif
    input  logic              host_we,
    input  logic [REG_AW-1:0] host_waddr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic [REG_AW-1:0] dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_cf,
    input  logic              alu_ovf,
    input  logic              alu_z,
    input  logic              alu_neg,
    output logic [3:0]        flags,
    output logic              done
);

    import alu_pkg::*;

    state_t            r_state, w_next;
    logic              w_accept;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] r_alu_a, r_alu_b;
    logic [2:0]        r_alu_op;
    logic [3:0]        r_flags;
    logic              r_done;
    logic [DATA_W-1:0] w_rs1_data, w_rs2_data, w_opb;
    logic              w_wb_we;

    alu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .REG_AW(REG_AW)) u_rf (
        .clk         (clk),
        .areset      (areset),
        .i_rs1_addr  (in_rs1),
        .i_rs2_addr  (in_rs2),
        .i_dbg_addr  (dbg_raddr),
        .o_rs1_data  (w_rs1_data),
        .o_rs2_data  (w_rs2_data),
        .o_dbg_data  (dbg_rdata),
        .i_wb_we     (w_wb_we),
        .i_wb_addr   (r_rd),
        .i_wb_data   (alu_result),
        .i_host_we   (host_we),
        .i_host_addr (host_waddr),
        .i_host_data (host_wdata)
    );

`ifdef ALU_ISSUE_IMM_EN
    assign w_opb = in_use_imm ? in_imm : w_rs2_data;
`else
    assign w_opb = w_rs2_data;
`endif

    always_ff @(posedge clk) begin
        if (!areset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: if (in_valid) begin
                w_accept = 1'b1;
                w_next   = EXEC;
            end
            EXEC: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Writeback happens on the edge that ends EXEC; a reset on that edge
    // wins because the register file clears at the same time.
    assign w_wb_we  = (r_state == EXEC);
    assign in_ready = (r_state == IDLE);

    always_ff @(posedge clk) begin
        if (!areset) begin
            r_rd     <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
            r_flags  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_wb_we;
            if (w_accept) begin
                r_alu_a  <= w_rs1_data;
                r_alu_b  <= w_opb;
                r_alu_op <= in_op;
                r_rd     <= in_rd;
            end
            if (w_wb_we) begin
                r_flags[FLAG_CF]  <= alu_cf;
                r_flags[FLAG_OVF] <= alu_ovf;
                r_flags[FLAG_Z]   <= alu_z;
                r_flags[FLAG_NEG] <= alu_neg;
            end
        end
    end

    assign alu_a  = r_alu_a;
    assign alu_b  = r_alu_b;
    assign alu_op = r_alu_op;
    assign flags  = r_flags;
    assign done   = r_done;

endmodule
